// File: rtl/vc_plane_scheduler.sv
// Round-robin VC plane scheduler with per-grant quantum.
// Serves one plane at a time; releases on tail, quantum expiry or stall.
module vc_plane_scheduler #(
  parameter int VC      = 4,
  parameter int QUANTUM = 2,
  parameter int INIT    = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [VC-1:0]          req,
  input  logic [VC-1:0]          credit,
  input  logic [VC-1:0]          tail,
  input  logic                   hold,
  output logic [VC-1:0]          grant,
  output logic [$clog2(VC)-1:0]  planeSel,
  output logic                   valid
);

  localparam int W  = $clog2(VC);
  localparam int CW = (QUANTUM > 1) ? $clog2(QUANTUM) : 1;

  typedef enum logic {IDLE, SERVE} state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  cur_q, cur_d;
  logic [W-1:0]  ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [VC-1:0] elig;
  logic          rel;

  function automatic logic [W-1:0] inc(input logic [W-1:0] c);
    return (c == W'(VC-1)) ? '0 : c + 1'b1;
  endfunction

  // First eligible plane scanning s, s+1, ... with wrap.
  function automatic logic [W-1:0] rr(
    input logic [VC-1:0] e,
    input logic [W-1:0]  s
  );
    logic [W-1:0] r;
    logic [W-1:0] idx;
    logic         f;
    r   = s;
    idx = s;
    f   = 1'b0;
    for (int i = 0; i < VC; i++) begin
      if (!f && e[idx]) begin
        r = idx;
        f = 1'b1;
      end
      idx = inc(idx);
    end
    return r;
  endfunction

  assign elig     = req & credit;
  assign planeSel = cur_q;
  assign valid    = (state_q == SERVE) & elig[cur_q]
                  & ~hold & ~rst;

  always_comb begin
    grant        = '0;
    grant[cur_q] = valid;
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    rel     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!hold && |elig) begin
          state_d = SERVE;
          cur_d   = rr(elig, ptr_q);
          cnt_d   = '0;
        end
      end
      SERVE: begin
        if (!hold) begin
          rel = !elig[cur_q] || tail[cur_q]
             || (cnt_q == CW'(QUANTUM-1));
          if (rel) begin
            ptr_d = inc(cur_q);
            cnt_d = '0;
            if (|elig) cur_d = rr(elig, inc(cur_q));
            else state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cur_q   <= W'(INIT);
      ptr_q   <= W'(INIT);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: doc/vc_plane_scheduler.md
VC_PLANE_SCHEDULER -- requirements
Module: vc_plane_scheduler

Interface
REQ-001 Parameter VC, default 4: number of VC planes (≥2).
REQ-002 Parameter QUANTUM, default 2: max consecutive flit transfers per plane grant (≥1).
REQ-003 Parameter INIT, default 0: plane index loaded into the current-plane register and the RR pointer at reset.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 req  input  VC  bit v = plane v has a flit ready.
REQ-007 credit  input  VC  bit v = downstream buffer of plane v has space.
REQ-008 tail  input  VC  bit v = flit currently offered by plane v is a tail flit.
REQ-009 hold  input  1  freeze scheduling; no transfer, no state change.
REQ-010 grant  output  VC  one-hot transfer grant, all-zero when no transfer.
REQ-011 planeSel  output  $clog2(VC)  index of the current plane; drives the plane selectors of the switch/VC logic.
REQ-012 valid  output  1  a flit transfer occurs this cycle.

Function
REQ-013 eligible[v] SHALL equal req[v] & credit[v].
REQ-014 The FSM SHALL have two states: IDLE and SERVE; registered state comprises state, cur (plane index), cnt (0..QUANTUM-1), ptr (RR pointer).
REQ-015 valid SHALL be (state==SERVE) & eligible[cur] & ~hold; grant SHALL be onehot(cur) when valid, else 0; planeSel SHALL equal cur at all times.
REQ-016 Outputs SHALL be combinational from registered state and current inputs; the decision for cycle n+1 is registered at the end of cycle n.
REQ-017 RR search from index s: the first eligible plane among s, s+1, ..., s+VC-1 (mod VC).
REQ-018 IDLE, hold=0, any eligible: next state SERVE, cur = RR search from ptr, cnt = 0; otherwise remain IDLE.
REQ-019 SERVE, hold=1: all state held; grant=0, valid=0.
REQ-020 SERVE, valid, ~tail[cur], cnt<QUANTUM-1: cnt increments; cur unchanged.
REQ-021 SERVE, valid, tail[cur] or cnt==QUANTUM-1 (release): ptr = cur+1 mod VC; if any eligible, cur = RR search from cur+1 (cur itself last, using this cycle's eligible), cnt = 0, remain SERVE; else IDLE.
REQ-022 SERVE, ~hold, ~eligible[cur]: no transfer; release per REQ-021 (cnt = 0), so a stalled plane never blocks others.
REQ-023 Tail and quantum expiry in the same cycle SHALL count as one release.
REQ-024 cur wraps VC-1 -> 0; cnt SHALL never exceed QUANTUM-1.
REQ-025 With a single eligible plane, that plane SHALL be re-granted every cycle without an IDLE bubble.
REQ-026 grant SHALL never have more than one bit set, and SHALL never be set for a plane with eligible=0.

Reset
REQ-027 rst=1 at a posedge SHALL set state=IDLE, cur=INIT, ptr=INIT, cnt=0; rst overrides hold and all other inputs.
REQ-028 During and in the cycle after reset, grant=0, valid=0, planeSel=INIT.
REQ-029 Reset asserted mid-SERVE SHALL abandon the current quantum; no grant in the following cycle.

Verification (VC=4, QUANTUM=2, INIT=0)
REQ-030 Reset, req=0000 for 10 cycles -> grant=0000, valid=0, planeSel=0 throughout.
REQ-031 req=1111, credit=1111, tail=0000 -> one IDLE cycle, then grant 0001,0001,0010,0010,0100,0100,1000,1000,0001...
REQ-032 req=0100, credit=1111, tail=0100 constantly -> after one IDLE cycle, grant=0100 every cycle, valid=1 continuously.
REQ-033 req=1111, credit[1] drops while cur=1, cnt=0 -> that cycle grant=0000; next cycle grant=0100, planeSel=2.
REQ-034 hold=1 for 3 cycles while serving plane 0 with cnt=1 -> grant=0000 for 3 cycles; after hold drops, one more 0001, then 0010.
REQ-035 rst=1 while serving plane 2 -> next cycle grant=0000, planeSel=0; with req=1111, first grant after rst deasserts is 0001.
